// File: rtl/button_debounce_if.sv
// Pushbutton pin and its conditioned outputs (level plus press/release pulses).
interface button_debounce_if;
    logic btn_raw;
    logic btn_level;
    logic btn_press;
    logic btn_release;

    modport master (
        output btn_raw,
        input  btn_level,
        input  btn_press,
        input  btn_release
    );

    modport slave (
        input  btn_raw,
        output btn_level,
        output btn_press,
        output btn_release
    );
endinterface

// File: rtl/button_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, debounce counter and a 4-state FSM
// producing a stable pressed level plus single-cycle press/release pulses.
module button_debounce #(
    parameter int DEBOUNCE_CYCLES = 20,
    parameter bit ACTIVE_LOW      = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    button_debounce_if.slave   bus
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t        state;
    logic [CW-1:0] cnt;
    logic          p;
    logic          s1, s2;
    logic          level_q, press_q, release_q;

    // Normalized so that 1 always means "pressed" regardless of board wiring.
    assign p = bus.btn_raw ^ ACTIVE_LOW;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= p;
            s2 <= s1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            press_q   <= 1'b0;
            release_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (s2) begin
                        state <= PRESS_WAIT;
                        cnt   <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_LAST) begin
                        state   <= PRESSED;
                        level_q <= 1'b1;
                        press_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESSED: begin
                    if (!s2) begin
                        state <= RELEASE_WAIT;
                        cnt   <= '0;
                    end
                end
                RELEASE_WAIT: begin
                    // A bounce back to pressed keeps the level high; only a full quiet run releases.
                    if (s2) begin
                        state <= PRESSED;
                    end else if (cnt == CNT_LAST) begin
                        state     <= IDLE;
                        level_q   <= 1'b0;
                        release_q <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state   <= IDLE;
                    level_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.btn_level   = level_q;
    assign bus.btn_press   = press_q;
    assign bus.btn_release = release_q;
endmodule
